// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces active-low push-buttons,
// then presents a clean active-high level and one-cycle press/release strobes.
//
// Ports:
//   Clock          system clock; all state is on its rising edge
//   Reset          asynchronous, active-high; clears all state
//   KEY            raw push-buttons, active-low, asynchronous to Clock
//   pressed        debounced level, active-high (1 = key held)
//   press_pulse    one-cycle strobe on each accepted press
//   release_pulse  one-cycle strobe on each accepted release
module key_conditioner #(
    parameter int NKEYS           = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [NKEYS-1:0] KEY,
    output logic [NKEYS-1:0] pressed,
    output logic [NKEYS-1:0] press_pulse,
    output logic [NKEYS-1:0] release_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NKEYS-1:0] s1;
    logic [NKEYS-1:0] s2;
    logic [CNT_W-1:0] cnt [NKEYS];

    // Two-flop synchroniser; inversion makes the internal view active-high.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= ~KEY;
            s2 <= s1;
        end
    end

    // Per-channel stability counter. Any cycle where the synchronised input
    // agrees with the accepted level throws away the accumulated count, so a
    // change is only accepted after DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pressed       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                press_pulse[i]   <= 1'b0;
                release_pulse[i] <= 1'b0;
                if (s2[i] == pressed[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    pressed[i]       <= s2[i];
                    press_pulse[i]   <= s2[i];
                    release_pulse[i] <= ~s2[i];
                    cnt[i]           <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus random key activity for
// key_conditioner, checked every cycle against a sliding-window model.
module tb_key_conditioner;

    localparam int N = 3;
    localparam int D = 4;

    logic         Clock;
    logic         Reset;
    logic [N-1:0] KEY;
    logic [N-1:0] pressed;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;

    int total = 0;
    int bad   = 0;

    key_conditioner #(
        .NKEYS          (N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .KEY          (KEY),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference model: hist[k] is the active-high key value sampled k+1
    // edges ago, so hist[1..D] are the values the second synchroniser
    // stage held over the last D edges. A level is accepted once all D of
    // those differ from the current accepted level.
    logic [N-1:0] hist [0:D];
    logic [N-1:0] m_pressed;
    logic [N-1:0] m_pp;
    logic [N-1:0] m_rp;

    function automatic logic all_differ(int i);
        for (int k = 1; k <= D; k++) begin
            if (hist[k][i] == m_pressed[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k <= D; k++) hist[k] <= '0;
            m_pressed <= '0;
            m_pp      <= '0;
            m_rp      <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (all_differ(i)) begin
                    m_pressed[i] <= ~m_pressed[i];
                    m_pp[i]      <= ~m_pressed[i];
                    m_rp[i]      <= m_pressed[i];
                end else begin
                    m_pp[i] <= 1'b0;
                    m_rp[i] <= 1'b0;
                end
            end
            for (int k = D; k > 0; k--) hist[k] <= hist[k-1];
            hist[0] <= ~KEY;
        end
    end

    // Continuous cycle-by-cycle comparison, away from the active edge.
    always @(negedge Clock) begin
        check("pressed", 32'(pressed), 32'(m_pressed));
        check("press_pulse", 32'(press_pulse), 32'(m_pp));
        check("release_pulse", 32'(release_pulse), 32'(m_rp));
        for (int i = 0; i < N; i++) begin
            check("pulse_excl", 32'(press_pulse[i] & release_pulse[i]), 0);
        end
    end

    task automatic hold(input logic [N-1:0] k, input int cycles);
        @(negedge Clock);
        KEY = k;
        repeat (cycles - 1) @(negedge Clock);
    endtask

    int npulse;

    initial begin
        KEY   = '1;
        Reset = 1'b1;
        #1;
        check("rst_pressed", 32'(pressed), 0);
        check("rst_pp", 32'(press_pulse), 0);
        check("rst_rp", 32'(release_pulse), 0);
        repeat (3) @(negedge Clock);
        Reset = 1'b0;

        // Clean press: edge 6 after the change.
        @(negedge Clock);
        KEY = 3'b101;
        repeat (6) @(posedge Clock);
        #1;
        check("clean_pressed", 32'(pressed), 32'h2);
        check("clean_pp", 32'(press_pulse), 32'h2);
        @(posedge Clock);
        #1;
        check("clean_pp_off", 32'(press_pulse), 0);
        check("clean_hold", 32'(pressed), 32'h2);

        // Release all, then bounce on key 1.
        hold(3'b111, 12);
        hold(3'b101, 3);
        hold(3'b111, 1);
        hold(3'b101, 3);
        hold(3'b111, 8);
        check("bounce_level", 32'(pressed[1]), 0);
        @(negedge Clock);
        KEY = 3'b101;
        repeat (6) @(posedge Clock);
        #1;
        check("bounce_then_press", 32'(press_pulse), 32'h2);
        hold(3'b101, 6);
        hold(3'b111, 10);

        // Release on key 0.
        hold(3'b110, 10);
        check("rel_pre", 32'(pressed), 32'h1);
        @(negedge Clock);
        KEY = 3'b111;
        repeat (6) @(posedge Clock);
        #1;
        check("rel_pulse", 32'(release_pulse), 32'h1);
        check("rel_level", 32'(pressed), 0);
        check("rel_no_press", 32'(press_pulse), 0);
        hold(3'b111, 6);

        // Simultaneous press.
        @(negedge Clock);
        KEY = 3'b000;
        repeat (6) @(posedge Clock);
        #1;
        check("simul_pp", 32'(press_pulse), 32'h7);
        hold(3'b000, 4);
        hold(3'b111, 10);

        // Reset in the middle of a count on key 2.
        @(negedge Clock);
        KEY = 3'b011;
        repeat (3) @(posedge Clock);
        #3;
        Reset = 1'b1;
        #1;
        check("midrst_pressed", 32'(pressed), 0);
        check("midrst_pp", 32'(press_pulse), 0);
        check("midrst_rp", 32'(release_pulse), 0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (6) @(posedge Clock);
        #1;
        check("midrst_press", 32'(press_pulse), 32'h4);
        hold(3'b111, 10);

        // Long hold on key 0: one strobe, counter stays in range.
        npulse = 0;
        @(negedge Clock);
        KEY = 3'b110;
        repeat (100) begin
            @(posedge Clock);
            #1;
            npulse += int'(press_pulse[0]);
            for (int i = 0; i < N; i++) begin
                check("cnt_range", 32'(dut.cnt[i] <= 3'd3), 1);
            end
        end
        check("sat_pulses", 32'(npulse), 1);
        hold(3'b111, 10);

        // Random activity with occasional asynchronous reset.
        repeat (3000) begin
            @(negedge Clock);
            if ($urandom_range(3) == 0) KEY = N'($urandom);
            if ($urandom_range(249) == 0) begin
                #3;
                Reset = 1'b1;
                #1;
                check("rnd_rst", 32'({pressed, press_pulse, release_pulse}), 0);
                @(negedge Clock);
                Reset = 1'b0;
            end
        end

        @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
